// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant selection. Round-robin with a last-granted history register by
// default; DMEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins ties).
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic update_i,
  input  logic granted_id_i,
  output logic grant_id_o,
  output logic any_req_o
);

  assign any_req_o = req0_i | req1_i;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_hist;
  assign unused_hist = ^{clk_i, rst_i, update_i, granted_id_i};

  assign grant_id_o = req0_i ? PORT_CORE : PORT_DBG;
`else
  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (update_i) last_d = granted_id_i;
  end

  // Resetting history to the debug port hands the first tie to the core.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= PORT_DBG;
    else       last_q <= last_d;
  end

  always_comb begin
    if (req0_i && req1_i) grant_id_o = ~last_q;
    else if (req1_i)      grant_id_o = PORT_DBG;
    else                  grant_id_o = PORT_CORE;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core (port 0) and debug (port 1) accesses onto a single-ported data
// memory with a fixed IDLE -> ACCESS -> RESP sequence. Tie policy: DMEM_ARB_FIXED_PRIO_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              grant_id,
  output logic              busy,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  // Handshake: a requester raises reqN_valid with its command and holds it until
  // ackN pulses; valid is sampled only in IDLE and ack lasts exactly one cycle.

  arb_state_e        state_q;
  logic              grant_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_write_q;
  logic              ack0_q;
  logic              ack1_q;

  logic win_id;
  logic any_req;

  rr_arbiter2 u_arb (
    .clk_i        (clk),
    .rst_i        (reset),
    .req0_i       (req0_valid),
    .req1_i       (req1_valid),
    .update_i     (state_q == RESP),
    .granted_id_i (grant_q),
    .grant_id_o   (win_id),
    .any_req_o    (any_req)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= PORT_CORE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_write_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q     <= win_id;
            wr_q        <= win_id ? req1_write : req0_write;
            addr_q      <= win_id ? req1_addr  : req0_addr;
            wdata_q     <= win_id ? req1_wdata : req0_wdata;
            mem_write_q <= win_id ? req1_write : req0_write;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          // Memory read is combinational, so the load word is ready this cycle.
          if (!wr_q) rdata_q <= mem_readdata;
          ack0_q  <= (grant_q == PORT_CORE);
          ack1_q  <= (grant_q == PORT_DBG);
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign rdata         = rdata_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != IDLE);
  assign mem_write     = mem_write_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;

endmodule
